branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
- Consumes the three branch condition flags (eq, signed lt, unsigned lt) for the control-flow instruction in Execute.
- Decodes funct3 and decides taken/not-taken; the core uses static not-taken prediction.
- On a taken branch or jump, issues a registered PC redirect and holds the IF/ID flush for a fixed window.
- Keeps branch/taken statistics counters for the CSR/debug path.

Parameters:
- FLUSH_CYCLES, 2, cycles flush_out stays high after a redirect (>=1)
- CNT_W, 32, width of the statistics counters

Ports:
- CLK  in  1  core clock
- RST  in  1  synchronous active-high reset
- ex_valid  in  1  Execute slot holds a live instruction
- ex_stall  in  1  pipeline stall; freezes the block
- is_branch  in  1  instruction is B-type
- is_jal  in  1  instruction is JAL
- is_jalr  in  1  instruction is JALR
- funct3  in  3  B-type condition code
- br_eq  in  1  rs1 == rs2
- br_lt  in  1  signed rs1 < rs2
- br_ltu  in  1  unsigned rs1 < rs2
- branch_target  in  32  PC + imm_b
- jal_target  in  32  PC + imm_j
- jalr_target  in  32  rs1 + imm_i (unmasked)
- redirect_valid  out  1  one-cycle pulse; fetch must load redirect_pc
- redirect_pc  out  32  new fetch address
- flush_out  out  1  squash IF/ID contents
- illegal_br  out  1  one-cycle pulse: reserved funct3 (010/011) seen
- branch_cnt  out  CNT_W  resolved B-type count
- taken_cnt  out  CNT_W  taken B-type plus jump count

Behaviour:
- Reset (RST high at a CLK edge): every output is 0, the FSM is in IDLE and the flush counter is 0. RST mid-flush aborts the flush immediately.
- The instruction is accepted only when ex_valid=1, ex_stall=0, state=IDLE and exactly one of is_branch/is_jal/is_jalr is set.
- If more than one type bit is set, the instruction is ignored.
- Condition decode by funct3:
  - 000 eq
  - 001 !eq
  - 100 lt
  - 101 !lt
  - 110 ltu
  - 111 !ltu
  - 010/011: not taken, illegal_br pulses the next cycle.
- JAL and JALR are always taken.
- Target selection:
  - B-type uses branch_target.
  - JAL uses jal_target.
  - JALR uses {jalr_target[31:1],1'b0}.
- Latency: all outputs are registered. redirect_valid and redirect_pc appear the cycle after acceptance.
- redirect_valid is high for exactly 1 cycle. redirect_pc holds its value until the next redirect.
- FSM:
  - IDLE -> FLUSH on an accepted taken instruction. The counter is loaded with FLUSH_CYCLES, and flush_out rises in the same cycle as redirect_valid.
  - FLUSH: flush_out=1 and the counter decrements each non-stalled cycle. Return to IDLE when it reaches 0.
  - flush_out is therefore high for exactly FLUSH_CYCLES unstalled cycles.
- In FLUSH, ex_valid instructions are wrong-path. They are ignored: no redirect, no counter change, no illegal_br.
- Not-taken B-type: no redirect and no flush, so a not-taken branch can be followed by a back-to-back accept in the next cycle.
- ex_stall=1: the FSM state, the counter and the statistics hold. Pulse outputs (redirect_valid, illegal_br) still fall after their one cycle, so a stall never stretches them.
- Statistics counters:
  - branch_cnt increments on every accepted B-type, including illegal funct3.
  - taken_cnt increments on every accepted taken instruction.
  - Both wrap modulo 2^CNT_W with no saturation.
- Flag consistency (br_eq with br_lt) is not checked; the flags are used as given.

Decomposition:
- Shared core package gets:
  - funct3 branch code localparams (BEQ, BNE, BLT, BGE, BLTU, BGEU)
  - the br_state_t enum {IDLE, FLUSH}
  - the ctrl_type_t encoding for branch/jal/jalr.
- Sub-module branch_cond_eval (combinational, funct3 plus flags -> taken, illegal) keeps the decode reusable by a future branch predictor. Everything else is one module.

Test Plan:
- BEQ with br_eq=1, branch_target=0x0000_0100 -> next cycle redirect_valid=1, redirect_pc=0x100; flush_out high for 2 cycles; taken_cnt=1, branch_cnt=1.
- BGEU with br_ltu=1 -> no redirect and flush_out=0, branch_cnt increments and taken_cnt is unchanged. A second BNE with br_eq=0 next cycle is accepted and redirects.
- JALR with jalr_target=0x0000_2003 -> redirect_pc=0x0000_2002; an ex_valid BEQ presented during the flush window is ignored and the counters are unchanged.
- funct3=010 B-type -> illegal_br pulses 1 cycle, no redirect, branch_cnt+1.
- JAL, then ex_stall=1 for 3 cycles in FLUSH -> redirect_valid is still a 1-cycle pulse and flush_out stays high for 2+3 cycles total.
- RST asserted in the 1st flush cycle -> the next cycle flush_out=0 and both counters are 0; a JAL presented one cycle after reset deasserts is accepted normally. Preload branch_cnt to 0xFFFF_FFFF via repeated stimulus or force, then one BEQ -> branch_cnt wraps to 0.

Source files
------------

// File: rtl/branch_resolver_pkg.sv
// Shared control-flow definitions: branch condition codes, resolver FSM states, control-transfer type.
package branch_resolver_pkg;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } br_state_t;

    typedef enum logic [1:0] {
        CT_NONE   = 2'd0,
        CT_BRANCH = 2'd1,
        CT_JAL    = 2'd2,
        CT_JALR   = 2'd3
    } ctrl_type_t;

    // Anything other than exactly one type bit is not a control transfer.
    function automatic ctrl_type_t decode_ctrl(input logic is_b, input logic is_j, input logic is_jr);
        case ({is_b, is_j, is_jr})
            3'b100:  return CT_BRANCH;
            3'b010:  return CT_JAL;
            3'b001:  return CT_JALR;
            default: return CT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Execute-stage control-flow bus: instruction/flags in, redirect/flush/statistics out.
interface branch_resolver_if #(
    parameter int CNT_W = 32
);
    logic             ex_valid;
    logic             ex_stall;
    logic             is_branch;
    logic             is_jal;
    logic             is_jalr;
    logic [2:0]       funct3;
    logic             br_eq;
    logic             br_lt;
    logic             br_ltu;
    logic [31:0]      branch_target;
    logic [31:0]      jal_target;
    logic [31:0]      jalr_target;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             flush_out;
    logic             illegal_br;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output ex_valid, ex_stall, is_branch, is_jal, is_jalr, funct3,
               br_eq, br_lt, br_ltu, branch_target, jal_target, jalr_target,
        input  redirect_valid, redirect_pc, flush_out, illegal_br, branch_cnt, taken_cnt
    );

    modport slave (
        input  ex_valid, ex_stall, is_branch, is_jal, is_jalr, funct3,
               br_eq, br_lt, br_ltu, branch_target, jal_target, jalr_target,
        output redirect_valid, redirect_pc, flush_out, illegal_br, branch_cnt, taken_cnt
    );
endinterface

// File: rtl/branch_resolver_cond_eval.sv
// Branch condition decode: funct3 + compare flags -> taken / reserved-code flag.
// Latency: combinational. Backpressure: none.
module branch_cond_eval
    import branch_resolver_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic       i_br_eq,
    input  logic       i_br_lt,
    input  logic       i_br_ltu,
    output logic       o_taken,
    output logic       o_illegal
);
    always_comb begin
        o_taken   = 1'b0;
        o_illegal = 1'b0;
        case (i_funct3)
            BEQ:     o_taken   = i_br_eq;
            BNE:     o_taken   = ~i_br_eq;
            BLT:     o_taken   = i_br_lt;
            BGE:     o_taken   = ~i_br_lt;
            BLTU:    o_taken   = i_br_ltu;
            BGEU:    o_taken   = ~i_br_ltu;
            default: o_illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/branch_resolver.sv
// Resolves Execute-stage branches/jumps against static not-taken prediction; registered redirect + timed IF/ID flush.
// Latency: 1 cycle accept->redirect. Backpressure: ex_stall freezes FSM, flush counter and statistics.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic               CLK,
    input  logic               RST,
    branch_resolver_if.slave   bus
);
    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

    br_state_t        r_state, w_state_nxt;
    logic [FC_W-1:0]  r_fcnt, w_fcnt_nxt;
    ctrl_type_t       w_ctype;
    logic             w_cond_taken, w_cond_illegal;
    logic             w_accept, w_taken, w_illegal;
    logic [31:0]      w_target;

    logic             r_redirect_vld;
    logic [31:0]      r_redirect_pc;
    logic             r_flush;
    logic             r_illegal;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_taken_cnt;

    branch_cond_eval u_cond (
        .i_funct3  (bus.funct3),
        .i_br_eq   (bus.br_eq),
        .i_br_lt   (bus.br_lt),
        .i_br_ltu  (bus.br_ltu),
        .o_taken   (w_cond_taken),
        .o_illegal (w_cond_illegal)
    );

    assign w_ctype   = decode_ctrl(bus.is_branch, bus.is_jal, bus.is_jalr);
    // Instructions seen while flushing are wrong-path and never accepted.
    assign w_accept  = bus.ex_valid & ~bus.ex_stall & (r_state == IDLE) & (w_ctype != CT_NONE);
    assign w_taken   = w_accept & ((w_ctype != CT_BRANCH) | w_cond_taken);
    assign w_illegal = w_accept & (w_ctype == CT_BRANCH) & w_cond_illegal;

    always_comb begin
        w_target = bus.branch_target;
        case (w_ctype)
            CT_JAL:  w_target = bus.jal_target;
            CT_JALR: w_target = bus.jalr_target & ~32'd1;
            default: w_target = bus.branch_target;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        case (r_state)
            IDLE: begin
                if (w_taken) begin
                    w_state_nxt = FLUSH;
                    w_fcnt_nxt  = FC_W'(FLUSH_CYCLES);
                end
            end
            FLUSH: begin
                if (!bus.ex_stall) begin
                    w_fcnt_nxt = r_fcnt - FC_W'(1);
                    if (r_fcnt == FC_W'(1)) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state        <= IDLE;
            r_fcnt         <= '0;
            r_redirect_vld <= 1'b0;
            r_redirect_pc  <= '0;
            r_flush        <= 1'b0;
            r_illegal      <= 1'b0;
            r_branch_cnt   <= '0;
            r_taken_cnt    <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_fcnt         <= w_fcnt_nxt;
            r_redirect_vld <= w_taken;
            r_flush        <= (w_state_nxt == FLUSH);
            r_illegal      <= w_illegal;
            if (w_taken) begin
                r_redirect_pc <= w_target;
                r_taken_cnt   <= r_taken_cnt + CNT_W'(1);
            end
            if (w_accept && (w_ctype == CT_BRANCH)) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.redirect_valid = r_redirect_vld;
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.flush_out      = r_flush;
    assign bus.illegal_br     = r_illegal;
    assign bus.branch_cnt     = r_branch_cnt;
    assign bus.taken_cnt      = r_taken_cnt;
endmodule

// File: tb/tb_branch_resolver.sv
// Directed + randomized bench for branch_resolver against a cycle-level behavioural model.
module tb_branch_resolver;
    import branch_resolver_pkg::*;

    localparam int CW = 8;
    localparam int FL = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    int          m_left = 0;
    logic [31:0] m_pc   = '0;
    int          m_bcnt = 0;
    int          m_tcnt = 0;
    logic        e_rv, e_ill, e_fl;
    int          flush_seen;

    branch_resolver_if #(.CNT_W(CW)) bus ();

    branch_resolver #(.FLUSH_CYCLES(FL), .CNT_W(CW)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_taken(input logic [2:0] f3, input logic eq, input logic lt, input logic ltu);
        case (f3)
            3'd0:    return eq;
            3'd1:    return !eq;
            3'd4:    return lt;
            3'd5:    return !lt;
            3'd6:    return ltu;
            3'd7:    return !ltu;
            default: return 1'b0;
        endcase
    endfunction

    // typ = {branch, jal, jalr}; tgt lands on the target the type selects, others random.
    task automatic drive(input logic v, input logic [2:0] typ, input logic [2:0] f3,
                         input logic eq, input logic lt, input logic ltu, input logic [31:0] tgt);
        bus.ex_valid      = v;
        bus.is_branch     = typ[2];
        bus.is_jal        = typ[1];
        bus.is_jalr       = typ[0];
        bus.funct3        = f3;
        bus.br_eq         = eq;
        bus.br_lt         = lt;
        bus.br_ltu        = ltu;
        bus.branch_target = typ[2] ? tgt : $urandom;
        bus.jal_target    = typ[1] ? tgt : $urandom;
        bus.jalr_target   = typ[0] ? tgt : $urandom;
    endtask

    task automatic idle();
        drive(1'b0, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    // Advance the model across one clock edge from the currently driven inputs, then compare.
    task automatic step();
        logic one, tk;
        int   n;
        e_rv  = 1'b0;
        e_ill = 1'b0;
        if (rst) begin
            m_left = 0; m_pc = '0; m_bcnt = 0; m_tcnt = 0;
        end else begin
            n   = int'(bus.is_branch) + int'(bus.is_jal) + int'(bus.is_jalr);
            one = bus.ex_valid && !bus.ex_stall && (m_left == 0) && (n == 1);
            if (m_left > 0 && !bus.ex_stall) m_left--;
            if (one) begin
                tk = 1'b1;
                if (bus.is_branch) begin
                    m_bcnt = (m_bcnt + 1) % (1 << CW);
                    tk = ref_taken(bus.funct3, bus.br_eq, bus.br_lt, bus.br_ltu);
                    if (bus.funct3 == 3'd2 || bus.funct3 == 3'd3) e_ill = 1'b1;
                end
                if (tk) begin
                    e_rv   = 1'b1;
                    m_tcnt = (m_tcnt + 1) % (1 << CW);
                    m_left = FL;
                    if (bus.is_branch)   m_pc = bus.branch_target;
                    else if (bus.is_jal) m_pc = bus.jal_target;
                    else                 m_pc = {bus.jalr_target[31:1], 1'b0};
                end
            end
        end
        e_fl = (m_left > 0);
        @(posedge clk);
        #1;
        check("redirect_valid", 32'(bus.redirect_valid), 32'(e_rv));
        check("redirect_pc",    bus.redirect_pc,         m_pc);
        check("flush_out",      32'(bus.flush_out),      32'(e_fl));
        check("illegal_br",     32'(bus.illegal_br),     32'(e_ill));
        check("branch_cnt",     32'(bus.branch_cnt),     32'(m_bcnt));
        check("taken_cnt",      32'(bus.taken_cnt),      32'(m_tcnt));
    endtask

    initial begin
        bus.ex_stall = 1'b0;
        idle();
        rst = 1'b1;
        step();
        step();
        check("reset_flush", 32'(bus.flush_out), 32'd0);
        rst = 1'b0;
        step();

        // Taken BEQ
        drive(1'b1, 3'b100, BEQ, 1'b1, 1'b0, 1'b0, 32'h0000_0100);
        step();
        check("beq_rv", 32'(bus.redirect_valid), 32'd1);
        check("beq_pc", bus.redirect_pc, 32'h0000_0100);
        idle();
        step();
        check("beq_flush2", 32'(bus.flush_out), 32'd1);
        step();
        check("beq_flush_end", 32'(bus.flush_out), 32'd0);
        check("beq_cnts", {16'(bus.branch_cnt), 16'(bus.taken_cnt)}, {16'd1, 16'd1});

        // Not-taken BGEU then back-to-back BNE
        drive(1'b1, 3'b100, BGEU, 1'b0, 1'b0, 1'b1, 32'h0000_0400);
        step();
        check("bgeu_nt", {31'd0, bus.redirect_valid}, 32'd0);
        drive(1'b1, 3'b100, BNE, 1'b0, 1'b0, 1'b0, 32'h0000_0800);
        step();
        check("bne_b2b_pc", bus.redirect_pc, 32'h0000_0800);
        idle();
        step();
        step();

        // JALR with wrong-path BEQ during flush
        drive(1'b1, 3'b001, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0000_2003);
        step();
        check("jalr_pc", bus.redirect_pc, 32'h0000_2002);
        drive(1'b1, 3'b100, BEQ, 1'b1, 1'b0, 1'b0, 32'h0000_0300);
        step();
        step();
        check("wrongpath_pc", bus.redirect_pc, 32'h0000_2002);
        idle();
        step();

        // Reserved funct3
        drive(1'b1, 3'b100, 3'b010, 1'b1, 1'b1, 1'b1, 32'h0000_0500);
        step();
        check("illegal_pulse", 32'(bus.illegal_br), 32'd1);
        idle();
        step();
        check("illegal_fall", 32'(bus.illegal_br), 32'd0);

        // JAL with a 3-cycle stall inside the flush window
        flush_seen = 0;
        drive(1'b1, 3'b010, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0000_3000);
        step();
        flush_seen += int'(bus.flush_out);
        idle();
        bus.ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            flush_seen += int'(bus.flush_out);
        end
        check("stall_rv_pulse", 32'(bus.redirect_valid), 32'd0);
        bus.ex_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            flush_seen += int'(bus.flush_out);
        end
        check("stall_flush_len", 32'(flush_seen), 32'd5);

        // Reset during first flush cycle
        drive(1'b1, 3'b010, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0000_4000);
        step();
        idle();
        rst = 1'b1;
        step();
        check("rst_midflush", {30'd0, bus.flush_out, bus.redirect_valid}, 32'd0);
        rst = 1'b0;
        step();
        drive(1'b1, 3'b010, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0000_5000);
        step();
        check("post_rst_jal", bus.redirect_pc, 32'h0000_5000);
        idle();
        step();
        step();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            int sel;
            logic [2:0] typ;
            sel = $urandom_range(0, 9);
            if (sel < 5)       typ = 3'b100;
            else if (sel < 7)  typ = 3'b010;
            else if (sel == 7) typ = 3'b001;
            else if (sel == 8) typ = 3'($urandom);
            else               typ = 3'b000;
            drive(($urandom_range(0, 9) < 7), typ, 3'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), $urandom);
            bus.ex_stall = ($urandom_range(0, 5) == 0);
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        bus.ex_stall = 1'b0;

        // Counter wrap
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < (1 << CW) - 1; i++) begin
            drive(1'b1, 3'b100, BEQ, 1'b0, 1'b0, 1'b0, 32'h0000_0600);
            step();
        end
        check("cnt_max", 32'(bus.branch_cnt), 32'h0000_00FF);
        drive(1'b1, 3'b100, BEQ, 1'b1, 1'b0, 1'b0, 32'h0000_0700);
        step();
        check("cnt_wrap", 32'(bus.branch_cnt), 32'd0);
        check("cnt_wrap_taken", 32'(bus.taken_cnt), 32'd1);
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
